// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Holds a 16-slot program of 12-bit instructions and drives the
//            tiny 4-bit ALU one instruction at a time. Each ALU instruction
//            takes FETCH, ISSUE, WAIT and CAPTURE. The result is captured after
//            the ALU's two-register latency and streamed out with the slot
//            that produced it. HALT, JMP and BZ are handled locally.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int MAX_STEPS = 255,
  parameter int STEP_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [11:0] prog_data,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  alu_ui_in,
  output logic [7:0]  alu_uio,
  input  logic [7:0]  alu_uo_out,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic [3:0]  res_pc,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  // Sequencer-only opcodes; everything below 0xC goes to the ALU unchanged.
  localparam logic [3:0]        OP_HALT    = 4'hC;
  localparam logic [3:0]        OP_BZ      = 4'hD;
  localparam logic [3:0]        OP_JMP     = 4'hE;
  localparam logic [11:0]       INSTR_HALT = 12'hC00;
  localparam logic [7:0]        ALU_NOP    = 8'h0F;
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [3:0]        PC_ONE     = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [11:0]         prog_mem [16];
  logic [STEP_W-1:0]   step_cnt, step_cnt_n;
  logic                last_zero, last_zero_n;

  logic [3:0]          pc_n;
  logic                busy_n, done_n, res_valid_n, timeout_n;
  logic [7:0]          res_data_n;
  logic [3:0]          res_pc_n;
  logic [7:0]          alu_ui_in_n, alu_uio_n;

  // Current instruction fields.
  logic [11:0]         instr;
  logic [3:0]          instr_op;
  logic [3:0]          instr_a;

  assign instr    = prog_mem[pc];
  assign instr_op = instr[11:8];
  assign instr_a  = instr[3:0];

  // Program memory: resets to all-HALT, writable only while no run is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        prog_mem[i] <= INSTR_HALT;
      end
    end else if (prog_we && !busy) begin
      prog_mem[prog_addr] <= prog_data;
    end
  end

  // State and output register bank; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'd0;
      res_pc    <= 4'd0;
      timeout   <= 1'b0;
      last_zero <= 1'b0;
      step_cnt  <= '0;
      alu_ui_in <= 8'd0;
      alu_uio   <= ALU_NOP;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      busy      <= busy_n;
      done      <= done_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_pc    <= res_pc_n;
      timeout   <= timeout_n;
      last_zero <= last_zero_n;
      step_cnt  <= step_cnt_n;
      alu_ui_in <= alu_ui_in_n;
      alu_uio   <= alu_uio_n;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    busy_n      = busy;
    done_n      = 1'b0;
    res_valid_n = 1'b0;
    res_data_n  = res_data;
    res_pc_n    = res_pc;
    timeout_n   = timeout;
    last_zero_n = last_zero;
    step_cnt_n  = step_cnt;
    alu_ui_in_n = alu_ui_in;
    alu_uio_n   = alu_uio;

    if (state == S_IDLE) begin
      // start beats a simultaneous stop; stop alone is meaningless here.
      if (start) begin
        pc_n        = 4'd0;
        step_cnt_n  = '0;
        timeout_n   = 1'b0;
        last_zero_n = 1'b0;
        busy_n      = 1'b1;
        state_n     = S_FETCH;
      end
    end else if (stop) begin
      // Abort drops any in-flight instruction without emitting its result.
      state_n     = S_IDLE;
      busy_n      = 1'b0;
      done_n      = 1'b1;
      alu_ui_in_n = 8'd0;
      alu_uio_n   = ALU_NOP;
    end else begin
      case (state)
        S_FETCH: begin
          if (step_cnt == STEP_LIMIT) begin
            timeout_n = 1'b1;
            done_n    = 1'b1;
            busy_n    = 1'b0;
            state_n   = S_IDLE;
          end else if (instr_op == OP_HALT) begin
            done_n    = 1'b1;
            busy_n    = 1'b0;
            state_n   = S_IDLE;
          end else if (instr_op == OP_JMP) begin
            pc_n       = instr_a;
            step_cnt_n = step_cnt + STEP_ONE;
          end else if (instr_op == OP_BZ) begin
            pc_n       = last_zero ? instr_a : pc + PC_ONE;
            step_cnt_n = step_cnt + STEP_ONE;
          end else begin
            // ALU op (including 0xF NOP): present {B,A} and op for three cycles.
            alu_ui_in_n = instr[7:0];
            alu_uio_n   = {4'h0, instr_op};
            state_n     = S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_n = S_WAIT;
        end
        S_WAIT: begin
          state_n = S_CAPTURE;
        end
        S_CAPTURE: begin
          // ALU output now reflects the instruction issued two edges ago.
          res_data_n  = alu_uo_out;
          res_pc_n    = pc;
          res_valid_n = 1'b1;
          last_zero_n = alu_uo_out[7];
          alu_ui_in_n = 8'd0;
          alu_uio_n   = ALU_NOP;
          pc_n        = pc + PC_ONE;
          step_cnt_n  = step_cnt + STEP_ONE;
          state_n     = S_FETCH;
        end
        default: begin
          state_n     = S_IDLE;
          busy_n      = 1'b0;
          alu_ui_in_n = 8'd0;
          alu_uio_n   = ALU_NOP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Self-checking bench for alu_op_sequencer with a two-register ALU
//            stand-in and an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  localparam int MAX_STEPS = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [11:0] prog_data = 12'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  alu_ui_in, alu_uio, alu_uo_out, res_data;
  logic        res_valid, busy, done, timeout;
  logic [3:0]  res_pc, pc;

  logic [7:0]  alu_stage = 8'd0;
  logic [7:0]  alu_out_q = 8'd0;
  assign alu_uo_out = alu_out_q;

  int passed = 0;
  int total  = 0;

  logic [11:0] prog [16];
  int   got_pc[$], got_data[$], got_k[$];
  int   exp_pc[$], exp_data[$], exp_k[$];
  int   done_k, exp_done_k;
  logic busy_k0, timeout_k0, exp_timeout;
  logic [3:0] exp_final_pc;

  alu_op_sequencer #(.MAX_STEPS(MAX_STEPS), .STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stop(stop),
    .alu_ui_in(alu_ui_in), .alu_uio(alu_uio), .alu_uo_out(alu_uo_out),
    .res_valid(res_valid), .res_data(res_data), .res_pc(res_pc), .pc(pc),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Tiny ALU stand-in: output {Z,S,V,C,result}; unknown ops and NOP give 0.
  function automatic logic [7:0] alu_fn(input logic [7:0] uio, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 4'd0;
    if (uio[7:4] != 4'h0) return 8'hEE;
    case (uio[3:0])
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'h1: begin r = a - b; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      default: return 8'h00;
    endcase
    return {(r == 4'd0), r[3], v, c, r};
  endfunction

  // Two register stages: inputs sampled at end of ISSUE, visible after WAIT.
  always @(posedge clk) begin
    alu_stage <= alu_fn(alu_uio, alu_ui_in[3:0], alu_ui_in[7:4]);
    alu_out_q <= alu_stage;
  end

  // Instruction-level model: ALU op costs 4 cycles, branch 1, final fetch 1.
  task automatic model_run();
    int p, steps, cyc;
    logic lz;
    logic [11:0] ins;
    logic [7:0] r;
    exp_pc.delete(); exp_data.delete(); exp_k.delete();
    p = 0; steps = 0; cyc = 0; lz = 1'b0; exp_timeout = 1'b0;
    for (int guard = 0; guard < 300; guard++) begin
      if (steps == MAX_STEPS) begin exp_timeout = 1'b1; break; end
      ins = prog[p];
      if (ins[11:8] == 4'hC) break;
      if (ins[11:8] == 4'hE) begin
        p = int'(ins[3:0]); steps++; cyc++;
      end else if (ins[11:8] == 4'hD) begin
        p = lz ? int'(ins[3:0]) : (p + 1) % 16; steps++; cyc++;
      end else begin
        r = alu_fn({4'h0, ins[11:8]}, ins[3:0], ins[7:4]);
        exp_pc.push_back(p); exp_data.push_back(int'(r)); exp_k.push_back(cyc + 4);
        lz = r[7]; p = (p + 1) % 16; steps++; cyc += 4;
      end
    end
    exp_done_k = cyc + 1;
    exp_final_pc = p[3:0];
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = i[3:0]; prog_data = prog[i];
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) prog[i] = 12'hC00;
  endtask

  // Start a run (optionally with a same-cycle slot-0 write or stop) and record results.
  task automatic run_dut(input int budget, input bit we_now, input logic [11:0] we_word, input bit stop_now);
    got_pc.delete(); got_data.delete(); got_k.delete(); done_k = -1;
    start = 1'b1; stop = stop_now;
    if (we_now) begin prog_we = 1'b1; prog_addr = 4'd0; prog_data = we_word; end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; prog_we = 1'b0;
    busy_k0 = busy; timeout_k0 = timeout;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) begin
        got_pc.push_back(int'(res_pc)); got_data.push_back(int'(res_data)); got_k.push_back(k);
      end
      if (done === 1'b1) begin done_k = k; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (alu_uio !== 8'h0F) $display("FAIL reset_alu_uio: got %h want 0f", alu_uio); else passed++;
    total++; if (alu_ui_in !== 8'h00) $display("FAIL reset_alu_ui_in: got %h want 00", alu_ui_in); else passed++;
    total++; if ({busy, done, res_valid, timeout} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, done, res_valid, timeout}); else passed++;
    total++; if ({pc, res_pc, res_data} !== 16'h0) $display("FAIL reset_regs: got %h want 0000", {pc, res_pc, res_data}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    total++; if ({busy, done} !== 2'b00) $display("FAIL stop_in_idle: got %b want 00", {busy, done}); else passed++;
  endtask

  task automatic test_empty_program();
    run_dut(10, 1'b0, 12'h000, 1'b0);
    total++; if (done_k !== 1) $display("FAIL empty_done_k: got %0d want 1", done_k); else passed++;
    total++; if (got_data.size() !== 0) $display("FAIL empty_results: got %0d want 0", got_data.size()); else passed++;
    total++; if (pc !== 4'd0) $display("FAIL empty_pc: got %0d want 0", pc); else passed++;
  endtask

  task automatic test_add();
    fill_halt();
    load_program();
    prog[0] = 12'h032;
    model_run();
    run_dut(30, 1'b1, 12'h032, 1'b0);
    total++; if (got_data.size() !== 1) $display("FAIL add_count: got %0d want 1", got_data.size()); else passed++;
    if (got_data.size() > 0) begin
      total++; if (got_data[0] !== 32'h05) $display("FAIL add_data: got %h want 05", got_data[0]); else passed++;
      total++; if (got_pc[0] !== 0) $display("FAIL add_pc: got %0d want 0", got_pc[0]); else passed++;
      total++; if (got_k[0] !== 4) $display("FAIL add_latency: got %0d want 4", got_k[0]); else passed++;
    end
    total++; if (done_k !== exp_done_k) $display("FAIL add_done_k: got %0d want %0d", done_k, exp_done_k); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL add_timeout: got %b want 0", timeout); else passed++;
  endtask

  task automatic test_branch();
    fill_halt();
    prog[0] = 12'h133; prog[1] = 12'hD03; prog[2] = 12'h011; prog[3] = 12'h0F7;
    load_program();
    model_run();
    run_dut(40, 1'b0, 12'h000, 1'b0);
    total++; if (got_data.size() !== 2) $display("FAIL bz_count: got %0d want 2", got_data.size()); else passed++;
    if (got_data.size() == 2) begin
      total++; if (got_data[0] !== 32'h80 || got_pc[0] !== 0) $display("FAIL bz_first: got %h@%0d want 80@0", got_data[0], got_pc[0]); else passed++;
      total++; if (got_data[1] !== 32'h16 || got_pc[1] !== 3) $display("FAIL bz_second: got %h@%0d want 16@3", got_data[1], got_pc[1]); else passed++;
    end
    total++; if (done_k !== exp_done_k) $display("FAIL bz_done_k: got %0d want %0d", done_k, exp_done_k); else passed++;
    total++; if (pc !== 4'd4) $display("FAIL bz_final_pc: got %0d want 4", pc); else passed++;
  endtask

  task automatic test_timeout();
    fill_halt();
    prog[0] = 12'hE00;
    load_program();
    run_dut(40, 1'b0, 12'h000, 1'b0);
    total++; if (done_k !== MAX_STEPS + 1) $display("FAIL to_done_k: got %0d want %0d", done_k, MAX_STEPS + 1); else passed++;
    total++; if ({timeout, busy} !== 2'b10) $display("FAIL to_flags: got %b want 10", {timeout, busy}); else passed++;
    total++; if (got_data.size() !== 0) $display("FAIL to_results: got %0d want 0", got_data.size()); else passed++;
    // Restart with stop in the same cycle: start must win and clear timeout.
    run_dut(40, 1'b0, 12'h000, 1'b1);
    total++; if ({busy_k0, timeout_k0} !== 2'b10) $display("FAIL to_restart: got %b want 10", {busy_k0, timeout_k0}); else passed++;
    total++; if (timeout !== 1'b1 || done_k !== MAX_STEPS + 1) $display("FAIL to_again: got %b/%0d want 1/%0d", timeout, done_k, MAX_STEPS + 1); else passed++;
  endtask

  task automatic test_stop_and_busy_write();
    int nres, ndone;
    logic [7:0] first;
    fill_halt();
    prog[0] = 12'h011; prog[1] = 12'h022; prog[2] = 12'h033;
    load_program();
    nres = 0; ndone = 0; first = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      prog_we = 1'b0;
      if (res_valid === 1'b1) begin nres++; first = res_data; end
      if (k == 2) begin prog_we = 1'b1; prog_addr = 4'd0; prog_data = 12'hC00; end
    end
    total++; if ({alu_uio, alu_ui_in} !== 16'h0022) $display("FAIL stop_issue_inputs: got %h want 0022", {alu_uio, alu_ui_in}); else passed++;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    total++; if ({done, busy, res_valid} !== 3'b100) $display("FAIL stop_pulse: got %b want 100", {done, busy, res_valid}); else passed++;
    total++; if ({alu_uio, alu_ui_in} !== 16'h0F00) $display("FAIL stop_nop: got %h want 0f00", {alu_uio, alu_ui_in}); else passed++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) nres++;
      if (done === 1'b1) ndone++;
    end
    total++; if (nres !== 1 || first !== 8'h02) $display("FAIL stop_results: got %0d/%h want 1/02", nres, first); else passed++;
    total++; if (ndone !== 0) $display("FAIL stop_extra_done: got %0d want 0", ndone); else passed++;
    model_run();
    run_dut(40, 1'b0, 12'h000, 1'b0);
    total++; if (got_data.size() !== 3) $display("FAIL busy_write_count: got %0d want 3", got_data.size()); else passed++;
    if (got_data.size() == 3) begin
      total++; if (got_data[0] !== 32'h02 || got_data[2] !== 32'h06) $display("FAIL busy_write_data: got %h,%h want 02,06", got_data[0], got_data[2]); else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] aluops [6];
    logic [3:0] op;
    aluops[0] = 4'h0; aluops[1] = 4'h1; aluops[2] = 4'h2;
    aluops[3] = 4'h3; aluops[4] = 4'h4; aluops[5] = 4'hF;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 9))
          6: op = 4'hD;
          7: op = 4'hE;
          8: op = 4'hC;
          default: op = aluops[$urandom_range(0, 5)];
        endcase
        prog[i] = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        if (op == 4'h1 && $urandom_range(0, 1) == 1) prog[i][7:4] = prog[i][3:0];
      end
      load_program();
      model_run();
      run_dut(60, 1'b0, 12'h000, 1'b0);
      total++; if (got_data.size() !== exp_data.size()) $display("FAIL rnd%0d_count: got %0d want %0d", it, got_data.size(), exp_data.size()); else passed++;
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
        total++;
        if (got_data[i] !== exp_data[i] || got_pc[i] !== exp_pc[i] || got_k[i] !== exp_k[i])
          $display("FAIL rnd%0d_res%0d: got %h@%0d k%0d want %h@%0d k%0d", it, i, got_data[i], got_pc[i], got_k[i], exp_data[i], exp_pc[i], exp_k[i]);
        else passed++;
      end
      total++; if (done_k !== exp_done_k) $display("FAIL rnd%0d_done_k: got %0d want %0d", it, done_k, exp_done_k); else passed++;
      total++; if (timeout !== exp_timeout || pc !== exp_final_pc) $display("FAIL rnd%0d_end: got to=%b pc=%0d want to=%b pc=%0d", it, timeout, pc, exp_timeout, exp_final_pc); else passed++;
    end
  endtask

  task automatic test_reset_mid_capture();
    fill_halt();
    prog[0] = 12'hE05; prog[5] = 12'h055;
    load_program();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin @(posedge clk); #1; end
    total++; if ({busy, pc, alu_uio} !== {1'b1, 4'd5, 8'h00}) $display("FAIL rst_pre_state: got %b/%0d/%h want 1/5/00", busy, pc, alu_uio); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, res_valid, timeout} !== 4'b0) $display("FAIL rst_mid_flags: got %b want 0000", {busy, done, res_valid, timeout}); else passed++;
    total++; if ({pc, res_pc, res_data, alu_ui_in, alu_uio} !== {4'd0, 4'd0, 8'h00, 8'h00, 8'h0F}) $display("FAIL rst_mid_regs: got %h want 000000f", {pc, res_pc, res_data, alu_ui_in, alu_uio}); else passed++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_dut(10, 1'b0, 12'h000, 1'b0);
    total++; if (done_k !== 1 || got_data.size() !== 0 || pc !== 4'd0) $display("FAIL rst_mem_halt: got k%0d n%0d pc%0d want k1 n0 pc0", done_k, got_data.size(), pc); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty_program();
    test_add();
    test_branch();
    test_timeout();
    test_stop_and_busy_write();
    test_random();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream driver for the tiny 4-bit ALU. It holds a small loadable program of ALU instructions and issues them one at a time on the ALU's ui_in/uio inputs. After the ALU's fixed two-register latency it captures uo_out and streams the result out. Sequencer-only opcodes provide halt, unconditional jump and branch-on-zero.

Parameters:
MAX_STEPS, 255, number of executed instructions after which a run stops with timeout (1..2^STEP_W-1)
STEP_W, 8, width of the executed-instruction counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
prog_we  input  1  program write strobe; honoured only when busy=0
prog_addr  input  4  program slot (16 slots)
prog_data  input  12  instruction {op[11:8], B[7:4], A[3:0]}
start  input  1  begin run at slot 0; ignored while busy=1
stop  input  1  abort the current run
alu_ui_in  output  8  {B,A} to ALU ui_in
alu_uio  output  8  {4'b0000, op} to ALU uio
alu_uo_out  input  8  ALU uo_out {Z,S,V,C,result[3:0]}
res_valid  output  1  one-cycle pulse: res_data/res_pc valid
res_data  output  8  captured alu_uo_out
res_pc  output  4  slot of the instruction that produced res_data
pc  output  4  current program counter
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of any run (halt, timeout, stop)
timeout  output  1  level; set when the run ended by MAX_STEPS; cleared on accepted start

Behaviour:
- Reset (async, rst_n=0): all 16 slots := 12'hC00 (HALT). pc=0, busy=0, done=0, res_valid=0, res_data=0, res_pc=0, timeout=0, last_zero=0, step count=0. alu_ui_in=0, alu_uio=8'h0F (NOP; ALU default yields 0, no regfile write).
- All outputs are registered.
- Reset asserted mid-run returns to IDLE immediately with the reset values above.
- Instruction classes:
  - op 0x0–0xB: ALU op, forwarded unchanged.
  - 0xC: HALT.
  - 0xD: BZ, branch to A if last_zero=1, else pc+1.
  - 0xE: JMP to A.
  - 0xF: NOP, forwarded as 0x0F, takes the full 3 cycles, produces a result.
- States: IDLE, FETCH, ISSUE, WAIT, CAPTURE.
- IDLE:
  - prog_we writes the slot on the clock edge.
  - start: pc:=0, step count:=0, timeout:=0, busy:=1, go to FETCH.
  - prog_we and start in the same cycle: the write occurs, then the run starts.
- FETCH (1 cycle): read slot[pc].
  - If step count == MAX_STEPS: timeout:=1, done pulse, go to IDLE.
  - HALT: done pulse, go to IDLE; pc holds the HALT slot.
  - JMP/BZ: update pc, step count+1, stay in FETCH. ALU inputs stay at NOP.
  - ALU op: load alu_ui_in={B,A}, alu_uio={0,op}, go to ISSUE.
- ISSUE, WAIT (1 cycle each): ALU inputs held stable.
  - ALU registers the result at the end of ISSUE.
  - uo_out updates at the end of WAIT.
- CAPTURE (1 cycle):
  - At the end of the cycle: res_data:=alu_uo_out, res_pc:=pc, res_valid pulses for the next cycle, last_zero:=alu_uo_out[7].
  - ALU inputs return to NOP.
  - pc:=pc+1, wrapping 15→0.
  - step count+1, go to FETCH.
- Throughput: one ALU instruction per 4 cycles (FETCH, ISSUE, WAIT, CAPTURE). Issue to res_valid = 3 edges.
- Holding REG_WRITE (op 0x8) for ISSUE+WAIT rewrites the same data. This is harmless by construction.
- stop while busy: next edge goes to IDLE, ALU inputs := NOP, done pulses, no res_valid for the in-flight instruction. stop in IDLE is ignored. stop and start in the same IDLE cycle: start wins.
- prog_we while busy: ignored; program memory unchanged.
- last_zero at run start is 0, so BZ before any ALU result falls through.
- Step count covers ALU ops and branches (JMP/BZ each count one step), not HALT.

Test Plan:
- Reset → alu_uio=0x0F, alu_ui_in=0, busy=0. Start with empty program → done pulse within 2 cycles, no res_valid, pc=0.
- Load slot0=0x032 (ADD A=2,B=3), slot1=0xC00; start → single res_valid, res_data=0x05, res_pc=0, asserted 4 cycles after first FETCH; then done, timeout=0.
- Load 0x133 (SUB 3-3), 0xD03 (BZ→3), 0x011, 0x0F7 (ADD A=7,B=15); start → res_data=0x80 (Z=1) at pc0, then res_data for pc3: 7+15 = 0x16 → result 6, carry 1, res_data=0x16; slot1's branch skips slot2.
- MAX_STEPS=5, program slot0=0xE00 (JMP 0) → done after 5 jumps, timeout=1, busy=0, no res_valid. Next start clears timeout.
- Run a 3-op program; assert stop during WAIT of op1 → done next cycle, alu_uio=0x0F, only op0 result emitted. Assert prog_we while busy → slot unchanged on re-run.
- rst_n pulsed low mid-CAPTURE → all outputs immediately at reset values and program memory reads back as HALT (start → immediate done).
